// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and width.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 3'b000,
    USR_SHR  = 3'b001,
    USR_SHL  = 3'b010,
    USR_LOAD = 3'b011,
    USR_ROR  = 3'b100,
    USR_ROL  = 3'b101,
    USR_ASR  = 3'b110,
    USR_CLR  = 3'b111
  } usr_mode_e;

endpackage

// File: rtl/usr_barrel.sv
// Combinational barrel shifter/rotator. Rotate paths exist only with USR_ROTATE_EN.
// k is assumed already clamped to 1..WIDTH-1 by the caller when the result is used.
module usr_barrel
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] data,
  input  usr_mode_e        mode,
  input  logic [KW-1:0]    k,
  input  logic             il,
  input  logic             ir,
  output logic [WIDTH-1:0] result,
  output logic             out_bit
);

  localparam logic [WIDTH-1:0] ONES = '1;
`ifdef USR_ROTATE_EN
  localparam logic [KW-1:0] K_WIDTH = KW'(WIDTH);
`endif

  logic [KW-1:0]    km1;
  logic [WIDTH-1:0] rtap;
  logic [WIDTH-1:0] ltap;

  // Shift/rotate data by k; rtap/ltap expose the last bit that leaves the register.
  always_comb begin
    km1     = k - KW'(1);
    rtap    = data >> km1;
    ltap    = data << km1;
    result  = data;
    out_bit = 1'b0;
    case (mode)
      USR_SHR: begin
        result  = (data >> k) | ({WIDTH{ir}} & ~(ONES >> k));
        out_bit = rtap[0];
      end
      USR_SHL: begin
        result  = (data << k) | ({WIDTH{il}} & ~(ONES << k));
        out_bit = ltap[WIDTH-1];
      end
      USR_ASR: begin
        result  = $unsigned($signed(data) >>> k);
        out_bit = rtap[0];
      end
`ifdef USR_ROTATE_EN
      USR_ROR: begin
        result  = (data >> k) | (data << (K_WIDTH - k));
        out_bit = rtap[0];
      end
      USR_ROL: begin
        result  = (data << k) | (data >> (K_WIDTH - k));
        out_bit = ltap[WIDTH-1];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/usr_shift_reg_n.sv
// Universal N-bit shift register with serial fill, load/clear, bit counting
// and a frame pulse every WIDTH shifted bits. Rotate modes need USR_ROTATE_EN.
module usr_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [AMT_W-1:0] amt,
  input  logic             il,
  input  logic             ir,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] out_bit,
  output logic             so,
  output logic             frame_done,
  output logic [AMT_W:0]   bit_cnt
);

  localparam int KW = AMT_W + 1;
  localparam logic [KW-1:0] K_WIDTH = KW'(WIDTH);
  localparam logic [KW-1:0] K_MAX   = KW'(WIDTH - 1);

  usr_mode_e        mode;
  logic [KW-1:0]    amt_x;
  logic [KW-1:0]    k;
  logic             shifting;
  logic [WIDTH-1:0] shift_result;
  logic             shift_so;
  logic [KW:0]      sum;
  logic [KW:0]      wrap;

  logic [WIDTH-1:0] out_bit_q, out_bit_d;
  logic             so_q, so_d;
  logic             frame_done_q, frame_done_d;
  logic [KW-1:0]    bit_cnt_q, bit_cnt_d;

  // Effective distance: shifts saturate at WIDTH-1, rotates wrap modulo WIDTH.
  always_comb begin
    mode     = usr_mode_e'(sel);
    amt_x    = {1'b0, amt};
    k        = (amt_x > K_MAX) ? K_MAX : amt_x;
    shifting = 1'b0;
    case (mode)
      USR_SHR, USR_SHL, USR_ASR: shifting = 1'b1;
`ifdef USR_ROTATE_EN
      USR_ROR, USR_ROL: begin
        k        = amt_x % K_WIDTH;
        shifting = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  usr_barrel #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_barrel (
    .data    (out_bit_q),
    .mode    (mode),
    .k       (k),
    .il      (il),
    .ir      (ir),
    .result  (shift_result),
    .out_bit (shift_so)
  );

  // Next-state decode; zero distance behaves as hold and the frame pulse self-clears.
  always_comb begin
    out_bit_d    = out_bit_q;
    so_d         = so_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    sum          = {1'b0, bit_cnt_q} + {1'b0, k};
    wrap         = sum - {1'b0, K_WIDTH};
    if (en) begin
      if (mode == USR_LOAD) begin
        out_bit_d = i;
        bit_cnt_d = '0;
      end else if (mode == USR_CLR) begin
        out_bit_d = '0;
        so_d      = 1'b0;
        bit_cnt_d = '0;
      end else if (shifting && (k != '0)) begin
        out_bit_d = shift_result;
        so_d      = shift_so;
        if (sum >= {1'b0, K_WIDTH}) begin
          bit_cnt_d    = wrap[KW-1:0];
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = sum[KW-1:0];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_bit_q    <= '0;
      so_q         <= 1'b0;
      frame_done_q <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      out_bit_q    <= out_bit_d;
      so_q         <= so_d;
      frame_done_q <= frame_done_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign out_bit    = out_bit_q;
  assign so         = so_q;
  assign frame_done = frame_done_q;
  assign bit_cnt    = bit_cnt_q;

endmodule
